fetch_unit: RTL and testbench

Instruction fetch controller for the 8-bit processor. It sits between `program_counter` and instruction memory. It reads the current PC, issues one memory request at a time, and captures the returned instruction. It then presents that instruction to the decoder over a valid/ready handshake and drives `program_counter`'s `pc_in` with the next PC: hold, increment, or redirect target.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch controller: issues one instruction-memory request at a time
// for the current PC, holds the returned word for the decoder, and computes the
// next PC (hold, increment or redirect target) for program_counter.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_cur,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHold,
        StDrain
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] PcOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  req_fire;

    // A redirect in flight blocks the request so the stale PC is never fetched.
    assign imem_req_valid = (state_q == StFetch) && !halt && !redirect_valid;
    assign imem_req_addr  = pc_cur;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Decoded from state so it drops as soon as reset asserts.
    assign instr_valid = (state_q == StHold);
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

    // Next PC: redirect wins, then advance on an accepted request, else hold.
    always_comb begin
        pc_next = pc_cur;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (req_fire) begin
            pc_next = pc_cur + PcOne;
        end
    end

    // Next-state and capture logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (req_fire) begin
                    instr_pc_d = pc_cur;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        state_d = StFetch;
                    end else begin
                        instr_data_d = imem_rsp_data;
                        state_d      = StHold;
                    end
                end else if (redirect_valid) begin
                    state_d = StDrain;
                end
            end
            StHold: begin
                // Ready and redirect together still count as a delivery.
                if (instr_ready || redirect_valid) begin
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (imem_rsp_valid) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and held-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural program counter and instruction memory with
// configurable latency, plus a scoreboard of expected deliveries.
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] pc_cur;
    logic [7:0] pc_next;
    logic       imem_req_valid;
    logic [7:0] imem_req_addr;
    logic       imem_req_ready;
    logic       imem_rsp_valid;
    logic [7:0] imem_rsp_data;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem [256];
    int          lat;
    logic        mem_pend;
    int          mem_cnt;
    logic [7:0]  mem_addr;
    logic        mem_killed;
    logic [15:0] sb_q[$];
    logic [15:0] sb_exp;

    fetch_unit #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_cur        (pc_cur),
        .pc_next       (pc_next),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, 16'(imem_req_valid), 16'd1);
    endtask

    task automatic wait_instr(input string tag);
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, 16'(instr_valid), 16'd1);
    endtask

    // Program counter model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_cur <= 8'h00;
        else        pc_cur <= pc_next;
    end

    // Instruction memory model; absorbs in-flight responses on reset.
    assign imem_rsp_valid = mem_pend && (mem_cnt == 1);
    assign imem_rsp_data  = imem_rsp_valid ? mem[mem_addr] : 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend   <= 1'b0;
            mem_cnt    <= 0;
            mem_addr   <= 8'h00;
            mem_killed <= 1'b0;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_pend   <= 1'b1;
            mem_cnt    <= lat;
            mem_addr   <= imem_req_addr;
            mem_killed <= 1'b0;
        end else if (mem_pend) begin
            if (redirect_valid) mem_killed <= 1'b1;
            if (mem_cnt == 1) begin
                mem_pend <= 1'b0;
                if (!(mem_killed || redirect_valid)) sb_q.push_back({mem_addr, mem[mem_addr]});
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // Scoreboard: compare each decoder handshake against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            check("sb_nonempty", 16'(sb_q.size() != 0), 16'd1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check("sb_data", 16'(instr_data), 16'(sb_exp[7:0]));
                check("sb_pc", 16'(instr_pc), 16'(sb_exp[15:8]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h00] = 8'hA1;
        mem[8'h01] = 8'hB2;
        mem[8'h02] = 8'hC3;
        mem[8'h40] = 8'h4D;
        mem[8'hFF] = 8'hEE;
        lat            = 1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        halt           = 1'b0;

        // Reset values.
        step();
        step();
        check("rst_instr_valid", 16'(instr_valid), 16'd0);
        check("rst_instr_data", 16'(instr_data), 16'd0);
        check("rst_instr_pc", 16'(instr_pc), 16'd0);
        check("rst_req_valid", 16'(imem_req_valid), 16'd0);
        check("rst_pc_next", 16'(pc_next), 16'h00);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h33;
        #1;
        check("rst_pc_next_redir", 16'(pc_next), 16'h33);
        redirect_valid = 1'b0;

        // Basic fetch: IDLE one cycle, then request for 0x00.
        rst_n = 1'b1;
        #1;
        check("idle_req_valid", 16'(imem_req_valid), 16'd0);
        step();
        check("bf_req_valid", 16'(imem_req_valid), 16'd1);
        check("bf_req_addr", 16'(imem_req_addr), 16'h00);
        check("bf_pc_next_inc", 16'(pc_next), 16'h01);
        step();
        check("bf_wait_valid", 16'(instr_valid), 16'd0);
        step();
        check("bf_i0_valid", 16'(instr_valid), 16'd1);
        check("bf_i0_data", 16'(instr_data), 16'hA1);
        check("bf_i0_pc", 16'(instr_pc), 16'h00);
        step();
        check("bf_req1_addr", 16'(imem_req_addr), 16'h01);
        step();
        instr_ready = 1'b0;
        step();
        check("bf_i1_valid", 16'(instr_valid), 16'd1);
        check("bf_i1_data", 16'(instr_data), 16'hB2);
        check("bf_i1_pc", 16'(instr_pc), 16'h01);

        // Decoder stall for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check("st_valid", 16'(instr_valid), 16'd1);
            check("st_data", 16'(instr_data), 16'hB2);
            check("st_pc", 16'(instr_pc), 16'h01);
            check("st_req_valid", 16'(imem_req_valid), 16'd0);
            check("st_pc_next", 16'(pc_next), 16'h02);
        end
        instr_ready = 1'b1;
        step();
        check("st_release_req", 16'(imem_req_valid), 16'd1);
        check("st_release_addr", 16'(imem_req_addr), 16'h02);
        step();

        // Redirect mid-flight with a 3-cycle memory.
        wait_req("rd_wait_fetch");
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h05;
        #1;
        check("rd_fetch_blocked", 16'(imem_req_valid), 16'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("rd_req5_addr", 16'(imem_req_addr), 16'h05);
        check("rd_req5_valid", 16'(imem_req_valid), 16'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        #1;
        check("rd_pc_next", 16'(pc_next), 16'h40);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rd_drain_req", 16'(imem_req_valid), 16'd0);
            check("rd_drain_valid", 16'(instr_valid), 16'd0);
            step();
        end
        check("rd_no_stale", 16'(instr_valid), 16'd0);
        check("rd_req40_valid", 16'(imem_req_valid), 16'd1);
        check("rd_req40_addr", 16'(imem_req_addr), 16'h40);
        step();

        // Wrap-around at 0xFF.
        wait_req("wr_wait_fetch");
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        step();
        redirect_valid = 1'b0;
        #1;
        check("wr_req_addr", 16'(imem_req_addr), 16'hFF);
        check("wr_pc_next", 16'(pc_next), 16'h00);
        step();
        wait_instr("wr_wait_instr");
        check("wr_instr_pc", 16'(instr_pc), 16'hFF);
        check("wr_instr_data", 16'(instr_data), 16'hEE);
        step();

        // Halt in FETCH, then halt during WAIT.
        wait_req("ht_wait_fetch");
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ht_req_valid", 16'(imem_req_valid), 16'd0);
            check("ht_pc_next", 16'(pc_next), 16'h00);
            step();
        end
        check("ht_pc_frozen", 16'(pc_cur), 16'h00);
        halt = 1'b0;
        #1;
        check("ht_release_req", 16'(imem_req_valid), 16'd1);
        step();
        halt = 1'b1;
        step();
        check("ht_wait_deliver", 16'(instr_valid), 16'd1);
        check("ht_wait_data", 16'(instr_data), 16'hA1);
        step();
        check("ht_fetch_blocked", 16'(imem_req_valid), 16'd0);
        halt        = 1'b0;
        instr_ready = 1'b0;
        wait_instr("ar_wait_hold");

        // Asynchronous reset while holding an instruction.
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_drop", 16'(instr_valid), 16'd0);
        check("ar_req_valid", 16'(imem_req_valid), 16'd0);
        check("ar_instr_data", 16'(instr_data), 16'd0);
        check("ar_instr_pc", 16'(instr_pc), 16'd0);
        sb_q.delete();
        step();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("ar_idle_req", 16'(imem_req_valid), 16'd0);
        step();
        check("ar_req_valid2", 16'(imem_req_valid), 16'd1);
        check("ar_req_addr", 16'(imem_req_addr), 16'h00);
        wait_instr("ar_wait_instr");
        check("ar_instr_data2", 16'(instr_data), 16'hA1);
        step();
        check("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
